// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data accesses win by default; a burst counter limits consecutive data grants while fetch waits.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_DM_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        owner
);

   localparam int CNT_W = $clog2(MAX_DM_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DM_BURST);
   localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUSY_IF = 2'b01,
      BUSY_DM = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              dm_ready_q, dm_ready_d;
   logic              if_req_m_s, dm_req_m_s;

   // A requester still showing its ready pulse cannot be granted again.
   assign if_req_m_s = if_req & ~if_ready_q;
   assign dm_req_m_s = dm_req & ~dm_ready_q;

   // Next-state and registered-output logic of the grant FSM.
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (dm_req_m_s && (!if_req_m_s || (burst_cnt_q < BURST_MAX))) begin
               state_d     = BUSY_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               if (if_req_m_s) begin
                  if (burst_cnt_q < BURST_MAX) begin
                     burst_cnt_d = burst_cnt_q + BURST_ONE;
                  end else begin
                     burst_cnt_d = burst_cnt_q;
                  end
               end else begin
                  burst_cnt_d = '0;
               end
            end else if (if_req_m_s) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               burst_cnt_d = '0;
            end else begin
               burst_cnt_d = '0;
            end
         end
         BUSY_IF: begin
            if (mem_ready) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               if_ready_d = 1'b1;
               if_rdata_d = mem_rdata;
            end else begin
               state_d = BUSY_IF;
            end
         end
         BUSY_DM: begin
            if (mem_ready) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               dm_ready_d = 1'b1;
               // Stores leave the last load result visible.
               if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata;
               end else begin
                  dm_rdata_d = dm_rdata_q;
               end
            end else begin
               state_d = BUSY_DM;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            burst_cnt_d = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_rdata_q  <= '0;
         dm_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_ready_q  <= dm_ready_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_ready  = dm_ready_q;
   assign owner     = state_q;
   assign if_stall  = if_req & ~if_ready_q;
   assign dm_stall  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requesters and a variable-latency memory are
// driven from the bench and every cycle is compared with a transaction-level reference.
module tb_mem_port_arbiter;

   localparam int MAX_BURST = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready, if_stall;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_ready, dm_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [1:0]  owner;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference: who owns the port (0 none, 1 fetch, 2 data) and the latched transaction.
   int          m_who;
   int          m_burst;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
   logic        m_we, m_if_rdy, m_dm_rdy;

   // Inputs as seen at the active edge.
   logic        c_rst, c_if_req, c_dm_req, c_dm_we, c_mem_ready;
   logic [31:0] c_if_addr, c_dm_addr, c_dm_wdata, c_mem_rdata;

   // Random-phase bookkeeping.
   bit if_after, dm_after;
   int wcnt, wdelay;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit take_if, take_dm;
      if (c_rst) begin
         m_who = 0; m_burst = 0; m_addr = 32'h0; m_wdata = 32'h0; m_we = 1'b0;
         m_if_rdy = 1'b0; m_dm_rdy = 1'b0; m_if_rdata = 32'h0; m_dm_rdata = 32'h0;
         return;
      end
      take_if = c_if_req && !m_if_rdy;
      take_dm = c_dm_req && !m_dm_rdy;
      m_if_rdy = 1'b0;
      m_dm_rdy = 1'b0;
      if (m_who == 0) begin
         if (take_dm && (!take_if || m_burst < MAX_BURST)) begin
            m_who = 2; m_addr = c_dm_addr; m_wdata = c_dm_wdata; m_we = c_dm_we;
            m_burst = take_if ? ((m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1) : 0;
         end else if (take_if) begin
            m_who = 1; m_addr = c_if_addr; m_we = 1'b0; m_burst = 0;
         end else begin
            m_burst = 0;
         end
      end else if (c_mem_ready) begin
         if (m_who == 1) begin
            m_if_rdy = 1'b1; m_if_rdata = c_mem_rdata;
         end else begin
            m_dm_rdy = 1'b1;
            if (!m_we) m_dm_rdata = c_mem_rdata;
            m_we = 1'b0;
         end
         m_who = 0;
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic tick();
      #1;
      chk_val("if_stall", {31'h0, if_stall}, {31'h0, if_req & ~m_if_rdy});
      chk_val("dm_stall", {31'h0, dm_stall}, {31'h0, dm_req & ~m_dm_rdy});
      c_rst = rst; c_if_req = if_req; c_dm_req = dm_req; c_dm_we = dm_we;
      c_mem_ready = mem_ready; c_if_addr = if_addr; c_dm_addr = dm_addr;
      c_dm_wdata = dm_wdata; c_mem_rdata = mem_rdata;
      @(posedge clk);
      #1;
      model_step();
      chk_val("owner",     {30'h0, owner},    m_who);
      chk_val("mem_req",   {31'h0, mem_req},  (m_who != 0) ? 32'h1 : 32'h0);
      chk_val("mem_we",    {31'h0, mem_we},   (m_who == 2) ? {31'h0, m_we} : 32'h0);
      chk_val("mem_addr",  mem_addr,  m_addr);
      chk_val("mem_wdata", mem_wdata, m_wdata);
      chk_val("if_ready",  {31'h0, if_ready}, {31'h0, m_if_rdy});
      chk_val("if_rdata",  if_rdata,  m_if_rdata);
      chk_val("dm_ready",  {31'h0, dm_ready}, {31'h0, m_dm_rdy});
      chk_val("dm_rdata",  dm_rdata,  m_dm_rdata);
      @(negedge clk);
   endtask

   // Memory answers after 0..5 extra cycles of mem_req.
   task automatic respond();
      if (!mem_req) begin
         mem_ready = 1'b0;
         wcnt = 0;
         wdelay = $urandom_range(0, 5);
      end else begin
         mem_ready = (wcnt == wdelay);
         mem_rdata = $urandom;
         wcnt++;
      end
   endtask

   // Requesters hold req through the ready cycle, then drop it or issue a new access.
   task automatic drive_random();
      if (if_ready) if_after = 1'b1;
      else if (if_after) begin
         if_after = 1'b0;
         if_req = $urandom_range(0, 1);
      end else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) if_addr = $urandom;
      if (dm_ready) dm_after = 1'b1;
      else if (dm_after) begin
         dm_after = 1'b0;
         dm_req = $urandom_range(0, 1);
      end else if (!dm_req) dm_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
         dm_addr = $urandom; dm_wdata = $urandom; dm_we = $urandom_range(0, 1);
      end
      rst = ($urandom_range(0, 99) == 0);
      respond();
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
      m_who = 0; m_burst = 0; m_addr = 32'h0; m_wdata = 32'h0; m_we = 1'b0;
      m_if_rdy = 1'b0; m_dm_rdy = 1'b0; m_if_rdata = 32'h0; m_dm_rdata = 32'h0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // Single load answered on the first mem_req cycle.
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      tick();
      chk_val("t2_addr", mem_addr, 32'h40);
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      chk_val("t2_ready", {31'h0, dm_ready}, 32'h1);
      chk_val("t2_rdata", dm_rdata, 32'hDEADBEEF);
      mem_ready = 1'b0;
      tick();
      dm_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_val("t6_noregrant", {31'h0, mem_req}, 32'h0);
      end

      // Simultaneous store and fetch: data first, fetch after one idle cycle.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
      if_req = 1'b1; if_addr = 32'h04;
      tick();
      chk_val("t3_we", {31'h0, mem_we}, 32'h1);
      chk_val("t3_wdata", mem_wdata, 32'h12345678);
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      chk_val("t3_rdata", dm_rdata, 32'hDEADBEEF);
      mem_ready = 1'b0; dm_req = 1'b0;
      tick();
      chk_val("t3_owner", {30'h0, owner}, 32'h1);
      chk_val("t3_addr", mem_addr, 32'h04);
      chk_val("t3_if_we", {31'h0, mem_we}, 32'h0);

      // Fetch with memory answering on the fifth mem_req cycle.
      for (int i = 0; i < 4; i++) begin
         if_addr = $urandom;
         tick();
         chk_val("t5_req", {31'h0, mem_req}, 32'h1);
         chk_val("t5_addr", mem_addr, 32'h04);
         chk_val("t5_early", {31'h0, if_ready}, 32'h0);
      end
      mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      tick();
      chk_val("t5_ready", {31'h0, if_ready}, 32'h1);
      chk_val("t5_rdata", if_rdata, 32'h0BADF00D);
      mem_ready = 1'b0; if_req = 1'b0;
      tick();
      chk_val("t5_single", {31'h0, if_ready}, 32'h0);

      // Both requesters held continuously against a random-latency memory.
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
      for (int i = 0; i < 80; i++) begin
         respond();
         tick();
      end

      if_after = 1'b0; dm_after = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         tick();
      end

      // Drain, then reset in the middle of a store.
      rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         respond();
         tick();
      end
      mem_ready = 1'b0;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hA5A5A5A5;
      tick();
      chk_val("t1_busy", {30'h0, owner}, 32'h2);
      rst = 1'b1; dm_req = 1'b0;
      tick();
      chk_val("t1_req", {31'h0, mem_req}, 32'h0);
      chk_val("t1_owner", {30'h0, owner}, 32'h0);
      chk_val("t1_ready", {31'h0, dm_ready}, 32'h0);
      rst = 1'b0;
      tick();
      chk_val("t1_noready", {31'h0, dm_ready}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
